// File: rtl/fv_arb_pkg.sv
// Shared types and constants for the FV FIFO write-side arbiter and read-side scheduler.
// FV_ARB_STATS_EN enables the per-requester statistics counters in fv_fifo_wr_arbiter.
`ifndef DEPTH_FV_FIFO
`define DEPTH_FV_FIFO 8
`endif

package fv_arb_pkg;

  localparam int STAT_W = 16;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Record handed from FV info producers to the FV FIFO.
  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  kind;
    logic [23:0] info;
  } FV_info2FV_FIFO;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fv_fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write/observe bus of the FV FIFO write arbiter.
interface fv_fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import fv_arb_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_last;
  FV_info2FV_FIFO [NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               fifo_rinc;
  logic                               fifo_rempty;
  logic                               fifo_winc;
  FV_info2FV_FIFO                     fifo_wdata;

  modport master (
    output req_valid, req_last, req_data, fifo_rinc, fifo_rempty,
    input  req_ready, fifo_winc, fifo_wdata
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_rinc, fifo_rempty,
    output req_ready, fifo_winc, fifo_wdata
  );

endinterface

// File: rtl/fv_rr_picker.sv
// Combinational round-robin search: first valid index at or above rr_ptr, wrapping.
module fv_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            s;
  logic [IW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = 0;
    k     = '0;
    for (int off = 0; off < N; off++) begin
      s = int'(rr_ptr) + off;
      if (s >= N) s = s - N;
      k = IW'(s);
      if (!any && valid[k]) begin
        grant[k] = 1'b1;
        idx      = k;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fv_fifo_wr_arbiter.sv
// Shares one FV_Sync_FIFO among NUM_REQ producers: round-robin with group lock, credit-gated writes.
// Define FV_ARB_STATS_EN to build the stat_beats / stat_stall counters (tied to 0 otherwise).
`ifndef DEPTH_FV_FIFO
`define DEPTH_FV_FIFO 8
`endif

module fv_fifo_wr_arbiter
  import fv_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DEPTH   = `DEPTH_FV_FIFO,
  parameter  int CNT_W   = $clog2(DEPTH) + 1,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                            wclk,
  input  logic                            rst,
  fv_fifo_wr_arbiter_if.slave             bus,
  output logic [CNT_W-1:0]                occupancy,
  output logic [IW-1:0]                   grant_id,
  output logic [NUM_REQ-1:0][STAT_W-1:0]  stat_beats,
  output logic [STAT_W-1:0]               stat_stall
);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      lock_id;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] ready;
  logic [IW-1:0]      acc_id;
  logic               credit_ok;
  logic               accept;
  logic               acc_last;
  logic               pop;

  fv_rr_picker #(.N(NUM_REQ)) u_pick (
    .valid  (bus.req_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Credits count beats from acceptance, so the counter never lags the real fill.
  assign credit_ok = (occupancy < CNT_W'(DEPTH));

  always_comb begin
    ready  = '0;
    acc_id = pick_idx;
    if (!rst) begin
      if (state == LOCK) begin
        ready[lock_id] = credit_ok;
        acc_id         = lock_id;
      end else begin
        ready = pick_grant & {NUM_REQ{credit_ok}};
      end
    end
  end

  assign bus.req_ready = ready;
  assign accept   = !rst && credit_ok &&
                    ((state == LOCK) ? bus.req_valid[lock_id] : pick_any);
  assign acc_last = bus.req_last[acc_id];
  // A pop at zero credit cannot be ours to refund; ignore it.
  assign pop      = bus.fifo_rinc && !bus.fifo_rempty && (occupancy != '0);

  always_ff @(posedge wclk) begin
    if (rst) begin
      state          <= ARB;
      rr_ptr         <= '0;
      lock_id        <= '0;
      grant_id       <= '0;
      occupancy      <= '0;
      bus.fifo_winc  <= 1'b0;
      bus.fifo_wdata <= '0;
    end else begin
      bus.fifo_winc <= accept;
      if (accept) begin
        bus.fifo_wdata <= bus.req_data[acc_id];
        grant_id       <= acc_id;
        if (acc_last) begin
          state  <= ARB;
          rr_ptr <= (acc_id == IW'(NUM_REQ - 1)) ? '0 : acc_id + 1'b1;
        end else begin
          state   <= LOCK;
          lock_id <= acc_id;
        end
      end
      if (accept && !pop)      occupancy <= occupancy + 1'b1;
      else if (!accept && pop) occupancy <= occupancy - 1'b1;
    end
  end

`ifdef FV_ARB_STATS_EN
  logic stall_cyc;
  assign stall_cyc = (|bus.req_valid) && !credit_ok;

  always_ff @(posedge wclk) begin
    if (rst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (accept && (acc_id == IW'(i))) stat_beats[i] <= sat_inc(stat_beats[i]);
      if (stall_cyc) stat_stall <= sat_inc(stat_stall);
    end
  end
`else
  assign stat_beats = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fv_fifo_wr_arbiter.sv
// Self-checking bench for fv_fifo_wr_arbiter: vector table, directed corner sequences, random vs model.
module tb_fv_fifo_wr_arbiter;
  import fv_arb_pkg::*;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;
  localparam int IW = $clog2(N);

  logic wclk = 1'b0;
  logic rst  = 1'b1;
  always #5 wclk = ~wclk;

  fv_fifo_wr_arbiter_if #(.NUM_REQ(N)) bus ();
  logic [CW-1:0]            occupancy;
  logic [IW-1:0]            grant_id;
  logic [N-1:0][STAT_W-1:0] stat_beats;
  logic [STAT_W-1:0]        stat_stall;

  fv_fifo_wr_arbiter #(.NUM_REQ(N), .DEPTH(D)) dut (
    .wclk       (wclk),
    .rst        (rst),
    .bus        (bus),
    .occupancy  (occupancy),
    .grant_id   (grant_id),
    .stat_beats (stat_beats),
    .stat_stall (stat_stall)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: credit count, next-priority index, group owner (-1 = none).
  int          m_occ, m_ptr, m_lock, m_gid, m_stall;
  int          m_beats[N];
  bit          m_winc;
  logic [31:0] m_wdata;
  logic [31:0] fq[$];   // the shared FIFO as seen by the environment

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (rst || m_occ >= D) return -1;
    if (m_lock >= 0) return m_lock;
    for (int o = 0; o < N; o++) begin
      int k = (m_ptr + o) % N;
      if (bus.req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_rinc = r;
    for (int i = 0; i < N; i++) bus.req_data[i] = FV_info2FV_FIFO'($urandom);
  endtask

  // Called one unit after an edge with inputs set; returns one unit after the next edge.
  task automatic step();
    int          c;
    logic [N-1:0] er;
    bit          acc, pp, fw, fr;
    logic [31:0] fd;
    #1;
    c  = model_pick();
    er = (c >= 0) ? (N'(1) << c) : '0;
    chk("req_ready", bus.req_ready, er);
    acc = (c >= 0) && bus.req_valid[c];
    pp  = bus.fifo_rinc && !bus.fifo_rempty && (m_occ > 0);
    fw  = bus.fifo_winc;
    fd  = bus.fifo_wdata;
    fr  = bus.fifo_rinc && !bus.fifo_rempty;
    @(posedge wclk);
    if (rst) fq.delete();
    else begin
      if (fw) chk("write_while_full", fq.size() < D, 1);
      if (fr) void'(fq.pop_front());
      if (fw) fq.push_back(fd);
    end
    if (rst) begin
      m_occ = 0; m_ptr = 0; m_lock = -1; m_gid = 0; m_winc = 0; m_wdata = '0; m_stall = 0;
      for (int i = 0; i < N; i++) m_beats[i] = 0;
    end else begin
      if ((|bus.req_valid) && m_occ >= D && m_stall < 65535) m_stall++;
      m_winc = acc;
      if (acc) begin
        m_wdata = bus.req_data[c];
        m_gid   = c;
        if (m_beats[c] < 65535) m_beats[c]++;
        if (bus.req_last[c]) begin
          m_lock = -1;
          m_ptr  = (c + 1) % N;
        end else m_lock = c;
      end
      m_occ = m_occ + int'(acc) - int'(pp);
    end
    #1;
    bus.fifo_rempty = (fq.size() == 0);
    chk("fifo_winc", bus.fifo_winc, m_winc);
    chk("fifo_wdata", bus.fifo_wdata, m_wdata);
    chk("occupancy", occupancy, m_occ);
    chk("grant_id", grant_id, m_gid);
`ifdef FV_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_beats", stat_beats[i], m_beats[i]);
    chk("stat_stall", stat_stall, m_stall);
`else
    chk("stat_beats_tied", stat_beats, 0);
    chk("stat_stall_tied", stat_stall, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         rinc;
    logic [N-1:0] ready;
    logic         winc;
    int           gid;
    int           occ;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n_winc;
    int n_acc;
    logic [N-1:0] lst;

    // All four requesting single beats, nothing draining: strict rotation until credits run out.
    tbl[0] = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1, 0, 1};
    tbl[1] = '{4'hF, 4'hF, 1'b0, 4'b0010, 1'b1, 1, 2};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 4'b0100, 1'b1, 2, 3};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 4'b1000, 1'b1, 3, 4};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1, 0, 5};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 4'b0010, 1'b1, 1, 6};
    tbl[6] = '{4'hF, 4'hF, 1'b0, 4'b0100, 1'b1, 2, 7};
    tbl[7] = '{4'hF, 4'hF, 1'b0, 4'b1000, 1'b1, 3, 8};
    tbl[8] = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, 3, 8};
    tbl[9] = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, 3, 8};

    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.req_data    = '0;
    bus.fifo_rinc   = 1'b0;
    bus.fifo_rempty = 1'b1;
    m_lock = -1;
    @(posedge wclk);
    #1;
    do_reset();
    chk("reset_occupancy", occupancy, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_winc", bus.fifo_winc, 0);
    chk("reset_wdata", bus.fifo_wdata, 0);

    n_winc = 0;
    foreach (tbl[r]) begin
      drive(tbl[r].valid, tbl[r].last, tbl[r].rinc);
      #1;
      chk("tbl_ready", bus.req_ready, tbl[r].ready);
      step();
      chk("tbl_winc", bus.fifo_winc, tbl[r].winc);
      chk("tbl_gid", grant_id, tbl[r].gid);
      chk("tbl_occ", occupancy, tbl[r].occ);
      if (bus.fifo_winc) n_winc++;
    end
    chk("tbl_winc_count", n_winc, 8);

    // Full FIFO: each pop frees exactly one credit, taken by req2 on the following cycle.
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(4'b0100, 4'hF, 1'b1);
      #1;
      chk("full_ready_pop", bus.req_ready, 4'b0000);
      step();
      chk("full_occ_pop", occupancy, 7);
      drive(4'b0100, 4'hF, 1'b0);
      #1;
      chk("full_ready_refill", bus.req_ready, 4'b0100);
      if (bus.req_ready[2]) n_acc++;
      step();
      chk("full_occ_refill", occupancy, 8);
    end
    chk("full_accepts_per_pop", n_acc, 6);

    // Simultaneous accept and pop, then underflow guard at zero.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 4'hF, 1'b0);
      step();
    end
    chk("occ_five", occupancy, 5);
    drive(4'b0001, 4'hF, 1'b1);
    step();
    chk("occ_acc_and_pop", occupancy, 5);
    for (int k = 0; k < 20 && m_occ != 0; k++) begin
      drive('0, '0, 1'b1);
      step();
    end
    chk("drain_to_zero", occupancy, 0);
    drive('0, '0, 1'b1);
    chk("empty_at_zero", bus.fifo_rempty, 1);
    step();
    chk("occ_no_underflow", occupancy, 0);

    // Three-beat group from req1 with an owner stall; others starve until last.
    do_reset();
    drive(4'b0001, 4'hF, 1'b0);
    step();
    chk("grp_pre_gid", grant_id, 0);
    drive(4'b1011, 4'b1001, 1'b0);
    #1; chk("grp_b1_ready", bus.req_ready, 4'b0010);
    step(); chk("grp_b1_gid", grant_id, 1);
    drive(4'b1001, 4'b1001, 1'b0);
    #1; chk("grp_stall_ready", bus.req_ready, 4'b0010);
    step(); chk("grp_stall_winc", bus.fifo_winc, 0);
    drive(4'b1011, 4'b1001, 1'b0);
    #1; chk("grp_b2_ready", bus.req_ready, 4'b0010);
    step(); chk("grp_b2_gid", grant_id, 1);
    drive(4'b1011, 4'b1011, 1'b0);
    #1; chk("grp_b3_ready", bus.req_ready, 4'b0010);
    step(); chk("grp_b3_gid", grant_id, 1);
    drive(4'b1011, 4'b1011, 1'b0);
    #1; chk("grp_after_ready", bus.req_ready, 4'b1000);
    step(); chk("grp_after_gid", grant_id, 3);

    // Reset while req2 holds a partial group.
    drive(4'b0100, 4'b0000, 1'b0);
    step();
    chk("mid_lock_gid", grant_id, 2);
    rst = 1'b1;
    drive(4'hF, 4'h0, 1'b0);
    #1; chk("rst_ready_zero", bus.req_ready, 4'b0000);
    step();
    rst = 1'b0;
    chk("rst_occ", occupancy, 0);
    chk("rst_winc", bus.fifo_winc, 0);
    chk("rst_gid", grant_id, 0);
    drive(4'hF, 4'hF, 1'b0);
    #1; chk("post_rst_ready", bus.req_ready, 4'b0001);
    step(); chk("post_rst_gid", grant_id, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) lst[i] = ($urandom_range(3) != 0);
      drive(N'($urandom), lst, 1'($urandom_range(1)));
      step();
    end

`ifdef FV_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 70000; k++) begin
      drive(4'b0001, 4'hF, 1'b1);
      step();
    end
    chk("stat_beats_saturated", stat_beats[0], 16'hFFFF);
`else
    chk("stat_beats_off", stat_beats, 0);
    chk("stat_stall_off", stat_stall, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
